// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selects, forwarding selects, scoreboard stage entry.
package cpu_types_pkg;

    localparam int REG_W    = 5;
    localparam int SB_DEPTH = 3;

    typedef logic [REG_W-1:0] regbits_t;

    // Forwarding select for the default scoreboard depth: 0 = regfile, k = stage k-1.
    typedef logic [$clog2(SB_DEPTH+1)-1:0] fwdsel_t;

    typedef struct packed {
        logic     valid;
        regbits_t wsel;
        logic     load;
    } sb_entry_t;

endpackage

// File: rtl/forward_sb_if.sv
// Decode/pipeline control bundle between the decode stage and the forwarding scoreboard.
interface forward_sb_if
    import cpu_types_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter int DEPTH = 3,
    parameter int CNTW  = 16
);
    logic                                   issue_valid;
    regbits_t [NSRC-1:0]                    issue_rsel;
    regbits_t                               issue_wsel;
    logic                                   issue_wen;
    logic                                   issue_load;
    logic                                   advance;
    logic                                   flush;
    logic [NSRC-1:0][$clog2(DEPTH+1)-1:0]   fwd_sel;
    logic                                   stall;
    logic [CNTW-1:0]                        stall_cnt;

    modport fsb (
        input  issue_valid, issue_rsel, issue_wsel, issue_wen, issue_load, advance, flush,
        output fwd_sel, stall, stall_cnt
    );

    modport tb (
        output issue_valid, issue_rsel, issue_wsel, issue_wen, issue_load, advance, flush,
        input  fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_match.sv
// One source operand: find the youngest in-flight writer of rsel and flag an early load.
module fwd_match
    import cpu_types_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FW       = $clog2(DEPTH+1)
) (
    input  sb_entry_t [DEPTH-1:0] ent_i,
    input  regbits_t              rsel_i,
    output logic [FW-1:0]         sel_o,
    output logic                  load_hz_o
);
    // Scan oldest to youngest so the lowest matching stage overwrites older hits.
    always_comb begin
        sel_o     = '0;
        load_hz_o = 1'b0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (ent_i[k].valid && ent_i[k].wsel != '0 && ent_i[k].wsel == rsel_i) begin
                sel_o     = FW'(k + 1);
                load_hz_o = ent_i[k].load && (k < LOAD_LAT);
            end
        end
    end
endmodule

// File: rtl/forward_scoreboard.sv
// In-flight destination tracker: operand forwarding selects, load-use stall, stall counter.
module forward_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = 16
) (
    input  logic      CLK,
    input  logic      nRST,
    forward_sb_if.fsb sb
);
    localparam int FW = $clog2(DEPTH+1);

    sb_entry_t [DEPTH-1:0]     stage_q, stage_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic [NSRC-1:0][FW-1:0]   sel;
    logic [NSRC-1:0]           hz;
    logic                      stall;

    for (genvar i = 0; i < NSRC; i++) begin : g_op
        fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FW(FW)) u_match (
            .ent_i     (stage_q),
            .rsel_i    (sb.issue_rsel[i]),
            .sel_o     (sel[i]),
            .load_hz_o (hz[i])
        );
    end

    assign stall        = sb.issue_valid & (|hz);
    assign sb.stall     = stall;
    assign sb.fwd_sel   = sel;
    assign sb.stall_cnt = cnt_q;

    // Stage shift on advance; a stalled or squashed decode enters EX as a bubble.
    always_comb begin
        stage_d = stage_q;
        if (sb.advance) begin
            for (int k = DEPTH-1; k >= 1; k--) begin
                stage_d[k] = stage_q[k-1];
            end
            if (sb.flush || stall) begin
                stage_d[0] = '0;
            end else begin
                stage_d[0].valid = sb.issue_valid & sb.issue_wen;
                stage_d[0].wsel  = sb.issue_wsel;
                stage_d[0].load  = sb.issue_load;
            end
        end else if (sb.flush) begin
            stage_d[0].valid = 1'b0;
        end
    end

    // Saturating count of cycles in which a stall actually cost an issue slot.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && sb.advance && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset drops every in-flight entry.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_forward_scoreboard;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    forward_sb_if #(.NSRC(2), .DEPTH(3), .CNTW(16)) ifa ();
    forward_sb_if #(.NSRC(3), .DEPTH(4), .CNTW(2))  ifb ();

    forward_scoreboard #(.NSRC(2), .DEPTH(3), .LOAD_LAT(1), .CNTW(16)) u_a (
        .CLK(clk), .nRST(rst_a), .sb(ifa.fsb)
    );
    forward_scoreboard #(.NSRC(3), .DEPTH(4), .LOAD_LAT(1), .CNTW(2)) u_b (
        .CLK(clk), .nRST(rst_b), .sb(ifb.fsb)
    );

    typedef struct packed {
        logic        dut;
        logic [2:0]  f0, f1, f2;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic void expect_out(input logic d, input string nm, input int f0, input int f1,
                                       input int f2, input logic st, input int cnt);
        exp_t e;
        e.dut = d; e.f0 = 3'(f0); e.f1 = 3'(f1); e.f2 = 3'(f2); e.st = st; e.cnt = 16'(cnt);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endfunction

    // Monitor: compare every pending expectation against the live outputs.
    logic [2:0]  af0, af1, af2;
    logic        ast;
    logic [15:0] acnt;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            if (!e.dut) begin
                af0 = 3'(ifa.fwd_sel[0]); af1 = 3'(ifa.fwd_sel[1]); af2 = 3'd0;
                ast = ifa.stall; acnt = 16'(ifa.stall_cnt);
            end else begin
                af0 = 3'(ifb.fwd_sel[0]); af1 = 3'(ifb.fwd_sel[1]); af2 = 3'(ifb.fwd_sel[2]);
                ast = ifb.stall; acnt = 16'(ifb.stall_cnt);
            end
            total++;
            if ({af0, af1, af2, ast, acnt} !== {e.f0, e.f1, e.f2, e.st, e.cnt}) begin
                bad++;
                $display("FAIL %s: got fwd=%0d/%0d/%0d stall=%0d cnt=%0d want fwd=%0d/%0d/%0d stall=%0d cnt=%0d",
                         nm, af0, af1, af2, ast, acnt, e.f0, e.f1, e.f2, e.st, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                           input logic [4:0] w, input logic wen, input logic ld,
                           input logic adv, input logic fl);
        ifa.issue_valid = v; ifa.issue_rsel[0] = r0; ifa.issue_rsel[1] = r1;
        ifa.issue_wsel = w; ifa.issue_wen = wen; ifa.issue_load = ld;
        ifa.advance = adv; ifa.flush = fl;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] w, input logic wen,
                           input logic ld, input logic adv);
        ifb.issue_valid = v; ifb.issue_rsel[0] = r0; ifb.issue_rsel[1] = r1;
        ifb.issue_rsel[2] = r2; ifb.issue_wsel = w; ifb.issue_wen = wen;
        ifb.issue_load = ld; ifb.advance = adv; ifb.flush = 1'b0;
    endtask

    task automatic idle_a(input int n);
        drive_a(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (n) tick();
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive_a(0, 0, 0, 0, 0, 0, 1, 0);
        drive_b(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b1;

        // Reset state
        expect_out(0, "reset", 0, 0, 0, 0, 0);
        tick();

        // ALU writer then dependent reader
        drive_a(1, 0, 0, 3, 1, 0, 1, 0);
        expect_out(0, "add3_issue", 0, 0, 0, 0, 0);
        tick();
        drive_a(1, 3, 0, 0, 0, 0, 1, 0);
        expect_out(0, "add3_fwd", 1, 0, 0, 0, 0);
        tick();
        idle_a(3);

        // Load-use: one stall cycle then forward from stage 1
        drive_a(1, 0, 0, 4, 1, 1, 1, 0);
        expect_out(0, "lw4_issue", 0, 0, 0, 0, 0);
        tick();
        drive_a(1, 0, 4, 0, 0, 0, 1, 0);
        expect_out(0, "lw4_stall", 0, 1, 0, 1, 0);
        tick();
        expect_out(0, "lw4_resolved", 0, 2, 0, 0, 1);
        tick();
        idle_a(3);

        // Youngest writer wins; $0 never forwards
        drive_a(1, 0, 0, 5, 1, 0, 1, 0);
        tick();
        drive_a(1, 5, 0, 5, 1, 0, 1, 0);
        expect_out(0, "w5_second", 1, 0, 0, 0, 1);
        tick();
        drive_a(1, 5, 0, 0, 1, 0, 1, 0);
        expect_out(0, "w5_youngest", 1, 0, 0, 0, 1);
        tick();
        drive_a(1, 0, 5, 0, 0, 0, 1, 0);
        expect_out(0, "r0_and_old5", 0, 2, 0, 0, 1);
        tick();
        idle_a(3);

        // Load-use while pipeline frozen
        drive_a(1, 0, 0, 6, 1, 1, 1, 0);
        expect_out(0, "lw6_issue", 0, 0, 0, 0, 1);
        tick();
        drive_a(1, 6, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expect_out(0, "lw6_frozen", 1, 0, 0, 1, 1);
            tick();
        end
        drive_a(1, 6, 0, 0, 0, 0, 1, 0);
        expect_out(0, "lw6_advance", 1, 0, 0, 1, 1);
        tick();
        expect_out(0, "lw6_resolved", 2, 0, 0, 0, 2);
        tick();
        idle_a(3);

        // Flush squashes the writer entering EX
        drive_a(1, 0, 0, 7, 1, 0, 1, 1);
        tick();
        drive_a(1, 7, 0, 0, 0, 0, 1, 0);
        expect_out(0, "flush7", 0, 0, 0, 0, 2);
        tick();
        idle_a(3);

        // Flush while frozen clears stage 0 only
        drive_a(1, 0, 0, 9, 1, 0, 1, 0);
        tick();
        drive_a(0, 9, 0, 0, 0, 0, 0, 1);
        expect_out(0, "w9_before_flush", 1, 0, 0, 0, 2);
        tick();
        drive_a(1, 9, 0, 0, 0, 0, 1, 0);
        expect_out(0, "w9_flushed", 0, 0, 0, 0, 2);
        tick();
        idle_a(3);

        // Reset in the middle of a stall
        drive_a(1, 0, 0, 11, 1, 1, 1, 0);
        tick();
        drive_a(1, 11, 0, 0, 0, 0, 1, 0);
        rst_a = 1'b0;
        expect_out(0, "lw11_stall", 1, 0, 0, 1, 2);
        tick();
        rst_a = 1'b1;
        expect_out(0, "after_reset", 0, 0, 0, 0, 0);
        tick();

        // Deeper build: match in the last stage, counter saturation
        rst_b = 1'b1;
        expect_out(1, "b_reset", 0, 0, 0, 0, 0);
        tick();
        drive_b(1, 0, 0, 0, 8, 1, 0, 1);
        tick();
        drive_b(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        drive_b(1, 8, 0, 8, 0, 0, 0, 1);
        expect_out(1, "b_w8_stage2", 3, 0, 3, 0, 0);
        tick();
        expect_out(1, "b_w8_stage3", 4, 0, 4, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_b(1, 0, 0, 0, 12, 1, 1, 1);
            tick();
            drive_b(1, 12, 0, 0, 0, 0, 0, 1);
            expect_out(1, "b_sat_stall", 1, 0, 0, 1, (i < 3) ? i : 3);
            tick();
            expect_out(1, "b_sat_after", 2, 0, 0, 0, (i + 1 < 3) ? i + 1 : 3);
            tick();
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL pending: got %0d unchecked want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
